conv_window_gen: RTL and testbench

Streaming 3x3 window generator that sits in front of the convolution unit. It accepts one raster-order pixel per valid beat, keeps the two previous image rows in line buffers, and presents the full nine-tap neighbourhood for every valid (no-padding) output position. The nine taps drive the 3x3 multiplier array, whose products are summed by the convolution adder tree.

---
 rtl/conv_window_gen.sv | 150 +++++++++++++++
 tb/tb_conv_window_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen
//
// Streaming 3x3 window generator placed in front of the convolution unit.
// Pixels arrive one per in_valid beat in raster order. The two previous image
// rows are kept in column-addressed line buffers. Every beat at position
// (r, c) with r >= 2 and c >= 2 completes a no-padding neighbourhood. That
// window is presented on the following cycle.
//
// Parameters:
//   WIDTH  pixel width in bits. Taps are opaque bits.
//   IMG_W  image width in pixels. The minimum is 3.
//   IMG_H  image height in pixels. The minimum is 3.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_pixel is valid this cycle. There is no backpressure.
//   in_pixel   pixel at the current raster position
//   out_valid  one-cycle pulse: win holds a new complete window
//   win        nine taps. Tap k = 3*i + j sits at [k*WIDTH +: WIDTH].
//              i = 0 is row r-2 and i = 2 is row r.
//              j = 0 is column c-2 and j = 2 is column c.
//   out_last   qualifies out_valid. It marks the last window of a frame.

module conv_window_gen #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_pixel,
  output logic                 out_valid,
  output logic [9*WIDTH-1:0]   win,
  output logic                 out_last
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  // Raster position of the pixel being accepted this cycle
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // Line buffers, addressed by column: lb1 holds row r-1 and lb2 holds row r-2
  logic [WIDTH-1:0] lb1_q [IMG_W];
  logic [WIDTH-1:0] lb2_q [IMG_W];
  logic [WIDTH-1:0] lb1_out, lb2_out;

  // 3x3 window registers. Index k = 3*i + j matches the win tap order.
  logic [WIDTH-1:0] tap_q [9];
  logic [WIDTH-1:0] tap_d [9];

  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;

  // Column-c entries are read before this beat's write. They are the pixels
  // one and two rows above.
  assign lb1_out = lb1_q[col_q];
  assign lb2_out = lb2_q[col_q];

  // Raster counters advance only on accepted beats
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == ColLast) begin
        col_d = '0;
        if (row_q == RowLast) begin
          row_d = '0;
        end else begin
          row_d = row_q + RowW'(1);
        end
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Window shift: each row moves one column left and the new column enters
  // at j = 2.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      tap_d[k] = tap_q[k];
    end
    if (in_valid) begin
      for (int i = 0; i < 3; i++) begin
        tap_d[3*i]     = tap_q[3*i + 1];
        tap_d[3*i + 1] = tap_q[3*i + 2];
      end
      tap_d[2] = lb2_out;
      tap_d[5] = lb1_out;
      tap_d[8] = in_pixel;
    end
  end

  // A window is complete only when all three columns come from the current
  // row span. Positions with c < 2 straddle a row wrap. Positions with r < 2
  // would use line-buffer contents from before the frame.
  always_comb begin
    out_valid_d = in_valid && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
    out_last_d  = in_valid && (row_q == RowLast) && (col_q == ColLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      for (int k = 0; k < 9; k++) begin
        tap_q[k] <= tap_d[k];
      end
    end
  end

  // The line buffers are not reset. Rows 0 and 1 of every frame overwrite
  // them before any window can be flagged valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_q[col_q] <= in_pixel;
      lb2_q[col_q] <= lb1_out;
    end
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < 9; k++) begin
      win[k*WIDTH +: WIDTH] = tap_q[k];
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  a_last_implies_valid : assert property (@(posedge clk) disable iff (rst)
    out_last_q |-> out_valid_q);

endmodule

// File: tb/tb_conv_window_gen.sv
`timescale 1ns/1ps

module tb_conv_window_gen;

  localparam int unsigned W = 9;

  logic clk = 1'b0;
  logic rst;

  logic           v4, v28, v3;
  logic [W-1:0]   p4, p28, p3;
  logic           ov4, ov28, ov3;
  logic           ol4, ol28, ol3;
  logic [9*W-1:0] w4, w28, w3;

  always #5 clk = ~clk;

  conv_window_gen #(.WIDTH(W), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_pixel(p4),
    .out_valid(ov4), .win(w4), .out_last(ol4)
  );

  conv_window_gen #(.WIDTH(W), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk(clk), .rst(rst), .in_valid(v28), .in_pixel(p28),
    .out_valid(ov28), .win(w28), .out_last(ol28)
  );

  conv_window_gen #(.WIDTH(W), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_pixel(p3),
    .out_valid(ov3), .win(w3), .out_last(ol3)
  );

  typedef struct {
    logic           vld;
    logic [W-1:0]   pix;
    logic           exp_ov;
    logic           exp_ol;
    logic [9*W-1:0] exp_win;
  } vec_t;

  vec_t vecs [16];

  int total = 0;
  int bad   = 0;
  int cnt4, cnt28, cnt3;
  logic [9*W-1:0] got4 [$];

  task automatic chk(input string name, input logic [9*W-1:0] act,
                     input logic [9*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [9*W-1:0] pack(input int t [9]);
    logic [9*W-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*W +: W] = W'(t[k]);
    return r;
  endfunction

  function automatic logic [9*W-1:0] add_off(input logic [9*W-1:0] w, input int off);
    logic [9*W-1:0] r;
    for (int k = 0; k < 9; k++) r[k*W +: W] = w[k*W +: W] + W'(off);
    return r;
  endfunction

  // Applies the first n table vectors to the 4x4 instance. Every tap and
  // pixel gets the offset off. gap idle cycles follow each beat.
  task automatic run4(input int n, input int off, input int gap, input string tag);
    for (int i = 0; i < n; i++) begin
      v4 = vecs[i].vld;
      p4 = vecs[i].pix + W'(off);
      @(posedge clk); #1;
      v4 = 1'b0;
      chk({tag, "_ov"}, 81'(ov4), 81'(vecs[i].exp_ov));
      chk({tag, "_ol"}, 81'(ol4), 81'(vecs[i].exp_ol));
      if (ov4) begin
        cnt4++;
        got4.push_back(w4);
      end
      if (vecs[i].exp_ov) chk({tag, "_win"}, w4, add_off(vecs[i].exp_win, off));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk({tag, "_gap_ov"}, 81'(ov4), 81'(0));
        chk({tag, "_gap_ol"}, 81'(ol4), 81'(0));
        if (ov4) cnt4++;
        if (vecs[i].exp_ov) chk({tag, "_gap_hold"}, w4, add_off(vecs[i].exp_win, off));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int img [28][28];
    logic [9*W-1:0] exp_w;
    logic [9*W-1:0] w5;
    logic eov, eol;

    // 4x4 frame with pixel = 4r + c
    for (int i = 0; i < 16; i++) begin
      vecs[i].vld     = 1'b1;
      vecs[i].pix     = W'(i);
      vecs[i].exp_ov  = 1'b0;
      vecs[i].exp_ol  = 1'b0;
      vecs[i].exp_win = '0;
    end
    vecs[10].exp_ov = 1'b1; vecs[10].exp_win = pack('{0, 1, 2, 4, 5, 6, 8, 9, 10});
    vecs[11].exp_ov = 1'b1; vecs[11].exp_win = pack('{1, 2, 3, 5, 6, 7, 9, 10, 11});
    vecs[14].exp_ov = 1'b1; vecs[14].exp_win = pack('{4, 5, 6, 8, 9, 10, 12, 13, 14});
    vecs[15].exp_ov = 1'b1; vecs[15].exp_win = pack('{5, 6, 7, 9, 10, 11, 13, 14, 15});
    vecs[15].exp_ol = 1'b1;

    rst = 1'b1;
    v4 = 1'b0; v28 = 1'b0; v3 = 1'b0;
    p4 = '0;   p28 = '0;   p3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov4", 81'(ov4), 81'(0));
    chk("rst_ol4", 81'(ol4), 81'(0));
    chk("rst_win4", w4, '0);
    chk("rst_ov28", 81'(ov28), 81'(0));
    chk("rst_win28", w28, '0);
    chk("rst_ov3", 81'(ov3), 81'(0));
    @(negedge clk);
    rst = 1'b0;

    // Two back-to-back 4x4 frames with continuous input
    cnt4 = 0;
    got4.delete();
    run4(16, 0, 0, "f1");
    run4(16, 100, 0, "f2");
    chk("two_frame_count", 81'(cnt4), 81'(8));
    w5 = (got4.size() >= 5) ? got4[4] : '0;
    chk("f2_first_win", w5, pack('{100, 101, 102, 104, 105, 106, 108, 109, 110}));

    // in_valid pattern 1,0,0,1,...
    cnt4 = 0;
    run4(16, 0, 2, "tog");
    chk("tog_count", 81'(cnt4), 81'(4));

    // Reset after pixel 9. All outputs must clear without a clock edge.
    run4(10, 0, 0, "pre");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ov", 81'(ov4), 81'(0));
    chk("midrst_ol", 81'(ol4), 81'(0));
    chk("midrst_win", w4, '0);
    @(negedge clk);
    rst = 1'b0;
    cnt4 = 0;
    run4(16, 0, 0, "post");
    chk("post_count", 81'(cnt4), 81'(4));

    // 28x28 random frames checked against a model
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) img[r][c] = int'($urandom_range(0, 511));
      cnt28 = 0;
      for (int r = 0; r < 28; r++) begin
        for (int c = 0; c < 28; c++) begin
          v28 = 1'b1;
          p28 = W'(img[r][c]);
          @(posedge clk); #1;
          v28 = 1'b0;
          eov = (r >= 2) && (c >= 2);
          eol = (r == 27) && (c == 27);
          chk("big_ov", 81'(ov28), 81'(eov));
          chk("big_ol", 81'(ol28), 81'(eol));
          if (ov28) cnt28++;
          if (eov) begin
            exp_w = '0;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                exp_w[(3*i + j)*W +: W] = W'(img[r - 2 + i][c - 2 + j]);
            chk("big_win", w28, exp_w);
          end
        end
      end
      chk("big_count", 81'(cnt28), 81'(676));
    end

    // Minimum 3x3 image: exactly one window per frame
    for (int f = 0; f < 2; f++) begin
      cnt3 = 0;
      for (int k = 0; k < 9; k++) begin
        v3 = 1'b1;
        p3 = W'(k + 20*f);
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("min_ov", 81'(ov3), 81'(k == 8));
        chk("min_ol", 81'(ol3), 81'(k == 8));
        if (ov3) cnt3++;
        if (k == 8) begin
          exp_w = '0;
          for (int t = 0; t < 9; t++) exp_w[t*W +: W] = W'(t + 20*f);
          chk("min_win", w3, exp_w);
        end
      end
      chk("min_count", 81'(cnt3), 81'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
